// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and helpers for the pipeline stage register.
//
// Contents:
//   PIPE_DATA_W  default width of one payload channel
//   PIPE_NUM_CH  default number of payload channels
//   OCC_W        width of the occupancy count (0..2 entries)
//   occ_count()  number of held entries given the two slot valid bits
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_NUM_CH = 8;
    localparam int OCC_W       = 2;

    // Two one-bit valids summed into the occupancy width.
    function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (valid bit + payload) of the stage register.
//
// Ports:
//   clk        clock, all updates on the rising edge
//   reset      synchronous active-high reset: valid=0, payload=0
//   clear      invalidate the entry (payload zeroed when BUBBLE_ZERO=1)
//   load       capture load_data and mark the entry valid
//   load_data  payload to capture
//   valid      entry holds data
//   data       held payload
//
// Priority is reset > clear > load.
module pipe_slot #(
    parameter int P           = 32,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [P-1:0] load_data,
    output logic         valid,
    output logic [P-1:0] data
);

    // With BUBBLE_ZERO=0 an invalidated entry keeps its old payload so the
    // downstream bus does not toggle on bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            if (BUBBLE_ZERO) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: fully registered valid/ready pipeline stage with a skid slot.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   flush      synchronous clear of both held entries; in_data that cycle is dropped
//   in_valid   upstream entry present
//   in_ready   stage can accept (registered, independent of out_ready)
//   in_data    upstream payload, channel k at [k*DATA_W +: DATA_W]
//   out_valid  downstream entry present
//   out_ready  downstream accepts (0 = stall)
//   out_data   downstream payload
//   occupancy  held entries, 0..2
//
// The main slot drives the outputs. The skid slot absorbs the one entry that
// can arrive while main is stalled, which lets in_ready come straight from a
// flop instead of from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = PIPE_DATA_W,
    parameter int NUM_CH      = PIPE_NUM_CH,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]         occupancy
);

    localparam int P = NUM_CH * DATA_W;

    logic         accept;
    logic         drain;
    logic         main_valid;
    logic [P-1:0] main_data;
    logic         main_load;
    logic         main_clear;
    logic [P-1:0] main_load_data;
    logic         skid_valid;
    logic [P-1:0] skid_data;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid_next;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    // Slot control. Skid is only ever written while main is full and stalled,
    // so a valid skid always implies a valid main, and on a drain the skid
    // entry is the next in order and moves forward before any new input.
    always_comb begin
        main_load       = 1'b0;
        main_clear      = 1'b0;
        main_load_data  = in_data;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;
        skid_valid_next = skid_valid;

        if (flush) begin
            main_clear      = 1'b1;
            skid_clear      = 1'b1;
            skid_valid_next = 1'b0;
        end else if (!main_valid) begin
            main_load = accept;
        end else if (drain) begin
            if (skid_valid) begin
                main_load       = 1'b1;
                main_load_data  = skid_data;
                skid_clear      = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            skid_load       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    pipe_slot #(
        .P           (P),
        .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_data (main_load_data),
        .valid     (main_valid),
        .data      (main_data)
    );

    pipe_slot #(
        .P           (P),
        .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    // in_ready is its own flop tracking the inverse of the skid valid bit it
    // will hold after this edge, so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= ~skid_valid_next;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg (DATA_W=16, NUM_CH=4).
//
// A behavioural occupancy/queue model predicts accepts and drains; accepted
// payloads are pushed when driven and the queue head is compared against
// out_data after every edge.
module tb_pipe_stage_reg;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int P      = DATA_W * NUM_CH;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_data;
    logic [1:0]   occupancy;

    int           errors = 0;
    int           checks = 0;
    logic [P-1:0] sb_q[$];
    int           m_occ = 0;
    int           m_accepts = 0;
    int           m_drains = 0;
    int           dut_drains = 0;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .BUBBLE_ZERO (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [P-1:0] observed, input logic [P-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against the model state after an edge.
    task automatic check_output(input string tag);
        logic [P-1:0] exp_data;
        exp_data = (sb_q.size() > 0) ? sb_q[0] : '0;
        check_value({tag, ".out_valid"}, P'(out_valid), P'(m_occ > 0));
        check_value({tag, ".in_ready"},  P'(in_ready),  P'(m_occ < 2));
        check_value({tag, ".occupancy"}, P'(occupancy), P'(m_occ));
        check_value({tag, ".out_data"},  out_data,      exp_data);
    endtask

    task automatic apply_stimulus(input logic v, input logic [P-1:0] d, input logic r,
                                  input logic f, input logic rst);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        reset     = rst;
    endtask

    // One clock: predict from pre-edge model state, advance, then check.
    task automatic cycle(input string tag);
        bit acc;
        bit drn;
        acc = in_valid && (m_occ < 2);
        drn = out_ready && (m_occ > 0);
        if (!reset && !flush && out_valid && out_ready) dut_drains++;
        @(posedge clk);
        #1;
        if (reset || flush) begin
            sb_q.delete();
            m_occ = 0;
        end else begin
            if (drn) begin
                void'(sb_q.pop_front());
                m_drains++;
            end
            if (acc) begin
                sb_q.push_back(in_data);
                m_accepts++;
            end
            m_occ = m_occ + int'(acc) - int'(drn);
        end
        check_output(tag);
    endtask

    initial begin
        apply_stimulus(1'b1, P'(64'hDEAD), 1'b1, 1'b0, 1'b1);

        // Reset ignores in_valid/out_ready.
        cycle("reset0");
        cycle("reset1");
        m_accepts = 0;
        m_drains  = 0;
        dut_drains = 0;

        // Streaming with no backpressure: latency one, occupancy 1.
        apply_stimulus(1'b1, P'(1), 1'b1, 1'b0, 1'b0);
        cycle("stream1");
        apply_stimulus(1'b1, P'(2), 1'b1, 1'b0, 1'b0);
        cycle("stream2");
        apply_stimulus(1'b1, P'(3), 1'b1, 1'b0, 1'b0);
        cycle("stream3");
        apply_stimulus(1'b0, P'(0), 1'b1, 1'b0, 1'b0);
        cycle("stream_idle");

        // Stall: fill main then skid; further input refused while full.
        apply_stimulus(1'b1, P'(16'hA), 1'b0, 1'b0, 1'b0);
        cycle("stall_a");
        apply_stimulus(1'b1, P'(16'hB), 1'b0, 1'b0, 1'b0);
        cycle("stall_b");
        apply_stimulus(1'b1, P'(16'hE), 1'b0, 1'b0, 1'b0);
        cycle("stall_hold0");
        cycle("stall_hold1");
        apply_stimulus(1'b0, P'(0), 1'b1, 1'b0, 1'b0);
        cycle("release_a");
        cycle("release_b");
        cycle("release_idle");

        // Flush with both slots full and a fresh input offered.
        apply_stimulus(1'b1, P'(16'h5), 1'b0, 1'b0, 1'b0);
        cycle("pre_flush0");
        apply_stimulus(1'b1, P'(16'h6), 1'b0, 1'b0, 1'b0);
        cycle("pre_flush1");
        apply_stimulus(1'b1, P'(16'hC), 1'b0, 1'b1, 1'b0);
        cycle("flush");
        apply_stimulus(1'b0, P'(0), 1'b1, 1'b0, 1'b0);
        cycle("post_flush0");
        cycle("post_flush1");

        // Reset and flush together with one held entry.
        apply_stimulus(1'b1, P'(16'h7), 1'b0, 1'b0, 1'b0);
        cycle("pre_reset");
        apply_stimulus(1'b1, P'(16'h8), 1'b1, 1'b1, 1'b1);
        cycle("reset_flush");
        apply_stimulus(1'b0, P'(0), 1'b1, 1'b0, 1'b0);
        cycle("post_reset");
        m_accepts  = 0;
        m_drains   = 0;
        dut_drains = 0;

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                           1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            cycle("random");
        end

        // Bounded final drain, then confirm every accepted entry came out.
        apply_stimulus(1'b0, P'(0), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle("final_drain");
        end
        check_value("drain_count", P'(dut_drains), P'(m_accepts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of one payload channel.
REQ-002 Parameter NUM_CH, default 8, number of payload channels; total payload width P = NUM_CH*DATA_W.
REQ-003 Parameter BUBBLE_ZERO, default 1: 1 = out_data forced to zero while out_valid=0; 0 = out_data holds last value.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of all held entries (kill/exception bubble).
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  stage can accept; registered output.
REQ-009 in_data  in  P  upstream payload, channel k at bits [k*DATA_W +: DATA_W].
REQ-010 out_valid  out  1  downstream entry present.
REQ-011 out_ready  in  1  downstream accepts (0 = stall).
REQ-012 out_data  out  P  downstream payload.
REQ-013 occupancy  out  2  held entries, 0..2.

Function
REQ-014 Accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated on the same edge.
REQ-015 Storage SHALL be two slots: main (drives out_data/out_valid) and skid.
REQ-016 Latency: payload accepted at edge N with main empty or draining SHALL appear on out_data after edge N.
REQ-017 Accept while main full and not draining SHALL write skid; in_ready SHALL be 0 from the next cycle.
REQ-018 Drain with skid full SHALL move skid to main and free skid; in_ready SHALL be 1 from the next cycle; a simultaneous accept is impossible (in_ready=0).
REQ-019 Accept and drain together with skid empty SHALL replace main; occupancy unchanged at 1.
REQ-020 Entries SHALL leave in acceptance order; no loss, no duplication.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain constant.
REQ-022 in_ready SHALL equal NOT(skid valid) as registered after each edge; never combinationally dependent on out_ready.
REQ-023 occupancy SHALL equal main valid + skid valid.
REQ-024 flush=1 at edge N SHALL invalidate both slots; in_data at edge N SHALL be discarded; after N: occupancy=0, out_valid=0, in_ready=1.
REQ-025 BUBBLE_ZERO=1: slot payload SHALL be cleared to zero whenever it becomes invalid (flush, drain without refill).
REQ-026 Priority: reset > flush > normal operation.

Reset
REQ-027 reset=1 at an edge SHALL set out_valid=0, out_data=0, occupancy=0, in_ready=1, both slots invalid with zero payload.
REQ-028 While reset=1, in_valid and out_ready SHALL be ignored; reset mid-transfer SHALL discard all held entries.

Structure
REQ-029 Shared package pipe_pkg SHALL hold DATA_W and NUM_CH defaults and OCC_W=2.
REQ-030 One sub-module pipe_slot (valid bit + P-bit payload with load/clear, sync reset) SHALL be instantiated twice (main, skid).
REQ-031 Total RTL SHALL be 120-400 lines, no latches, no asynchronous logic.

Verification
REQ-032 Stream 0x1,0x2,0x3 with out_ready=1 -> out_data 0x1,0x2,0x3 on the cycles after each accept, occupancy stays 1, in_ready stays 1.
REQ-033 out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after first drain.
REQ-034 occupancy 2 with flush=1 and in_valid=1 (0xC) -> next cycle occupancy 0, out_valid=0, out_data=0 (BUBBLE_ZERO=1), 0xC never emitted.
REQ-035 reset=1 and flush=1 together with occupancy 1 -> all outputs at reset values, in_ready=1.
REQ-036 Random in_valid/out_ready, NUM_CH=4, DATA_W=16, 10k cycles -> scoreboard order match, occupancy <= 2, no drop.
